// File: rtl/bf_loader.sv
// bf_loader: filters a byte stream into brainfuck program code for the
// core, writes the 0x00 terminator, starts the core and then forwards
// runtime ',' input until the core returns to ready.
//
// Ports:
//   clk, nrst                clock, async active-low reset
//   src_valid/ready/data     upstream byte source
//   bf_ready                 core is in its READY state
//   bf_start                 one-cycle start pulse to core
//   bf_in_valid/ack/data     byte handshake toward core
//   prog_len                 command bytes written (saturates at MAX_LEN)
//   overflow                 sticky: commands dropped past MAX_LEN
//   busy                     high in every state except LOAD
//   err                      bracket error (BF_LOADER_CHECK_EN builds)
//
// Optional feature: define BF_LOADER_CHECK_EN to add bracket checking.
module bf_loader #(
    parameter int unsigned MAX_LEN = 255
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       src_valid,
    output logic       src_ready,
    input  logic [7:0] src_data,
    input  logic       bf_ready,
    output logic       bf_start,
    output logic       bf_in_valid,
    input  logic       bf_in_ack,
    output logic [7:0] bf_in_data,
    output logic [7:0] prog_len,
    output logic       overflow,
    output logic       busy,
    output logic       err
);

`ifdef BF_LOADER_CHECK_EN
    typedef enum logic [2:0] {
        S_LOAD, S_TERM, S_START, S_RUN, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_LOAD, S_TERM, S_START, S_RUN
    } state_t;
`endif

    localparam logic [7:0] MAX = 8'(MAX_LEN);

    state_t     state;
    state_t     state_nxt;
    logic       buf_valid;
    logic [7:0] buf_data;
    logic       seen_busy;
    logic       is_cmd;
    logic       is_bang;
    logic       src_xfer;
    logic       core_xfer;
    logic       chk_fail;

    always_comb begin
        case (src_data)
            8'h2B, 8'h2D, 8'h3C, 8'h3E,
            8'h5B, 8'h5D, 8'h2E, 8'h2C: is_cmd = 1'b1;
            default:                    is_cmd = 1'b0;
        endcase
    end

    assign is_bang   = (src_data == 8'h21);
    assign src_xfer  = src_valid && src_ready;
    assign core_xfer = bf_in_valid && bf_in_ack;
    assign busy      = (state != S_LOAD);

`ifdef BF_LOADER_CHECK_EN
    logic [7:0] depth;
    logic       bad;

    assign chk_fail = bad || (depth != 8'd0);
    assign err      = (state == S_ERR);

    // Depth follows only bytes the core actually accepted as code.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            depth <= 8'd0;
            bad   <= 1'b0;
        end else if (state == S_RUN && state_nxt == S_LOAD) begin
            depth <= 8'd0;
            bad   <= 1'b0;
        end else if (state == S_LOAD && core_xfer) begin
            if (buf_data == 8'h5B) begin
                if (depth == 8'hFF) bad <= 1'b1;
                else depth <= depth + 8'd1;
            end else if (buf_data == 8'h5D) begin
                if (depth == 8'd0) bad <= 1'b1;
                else depth <= depth - 8'd1;
            end
        end
    end
`else
    assign chk_fail = 1'b0;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= S_LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        src_ready   = 1'b0;
        bf_in_valid = 1'b0;
        bf_in_data  = buf_data;
        bf_start    = 1'b0;
        unique case (state)
            S_LOAD: begin
                src_ready   = !buf_valid;
                bf_in_valid = buf_valid && bf_ready;
                if (src_xfer && is_bang) state_nxt = S_TERM;
            end
            // '!' is only taken with an empty buffer, so TERM
            // can drive the terminator straight away.
            S_TERM: begin
                bf_in_valid = 1'b1;
                bf_in_data  = 8'h00;
                if (bf_in_ack) begin
                    state_nxt = chk_fail ? state_t'(3'd4) : S_START;
                end
            end
            S_START: begin
                if (bf_ready) begin
                    bf_start  = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            // Runtime input only while the core is running, so
            // its READY-state code path never sees it.
            S_RUN: begin
                src_ready   = !buf_valid;
                bf_in_valid = buf_valid && !bf_ready;
                if (seen_busy && bf_ready) state_nxt = S_LOAD;
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            buf_valid <= 1'b0;
            buf_data  <= 8'h00;
            prog_len  <= 8'd0;
            overflow  <= 1'b0;
            seen_busy <= 1'b0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (core_xfer) begin
                        buf_valid <= 1'b0;
                        if (prog_len != MAX) prog_len <= prog_len + 8'd1;
                    end
                    if (src_xfer && is_cmd) begin
                        if (prog_len < MAX) begin
                            buf_valid <= 1'b1;
                            buf_data  <= src_data;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    seen_busy <= 1'b0;
                end
                S_RUN: begin
                    if (!bf_ready) seen_busy <= 1'b1;
                    if (core_xfer) buf_valid <= 1'b0;
                    if (src_xfer) begin
                        buf_valid <= 1'b1;
                        buf_data  <= src_data;
                    end
                    // Re-arm: leftover runtime input is dropped.
                    if (state_nxt == S_LOAD) begin
                        buf_valid <= 1'b0;
                        prog_len  <= 8'd0;
                        overflow  <= 1'b0;
                    end
                end
                default: begin
                    buf_valid <= buf_valid;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf_loader.sv
// Testbench for bf_loader: random and directed programs against a
// queue-based model of the bytes the core must receive.
module tb_bf_loader;

    localparam int MAX_LEN = 255;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       src_valid = 1'b0;
    logic       src_ready;
    logic [7:0] src_data = 8'h00;
    logic       bf_ready = 1'b1;
    logic       bf_start;
    logic       bf_in_valid;
    logic       bf_in_ack = 1'b0;
    logic [7:0] bf_in_data;
    logic [7:0] prog_len;
    logic       overflow;
    logic       busy;
    logic       err;

    int vectors = 0;
    int errors = 0;
    int start_cnt = 0;
    int ack_mode = 0;
    bit core_ready = 1'b1;

    // {kind, data}: kind 0 = code, 1 = terminator, 2 = runtime
    logic [9:0] exp_q[$];
    logic [7:0] pgm[$];
    logic [9:0] e_item;

    int   age = 0;
    bit   prev_pend = 1'b0;
    bit   prev_start = 1'b0;
    logic prev_ready = 1'b1;
    logic [7:0] prev_data = 8'h00;

    always #5 clk = ~clk;

    bf_loader #(.MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_data   (src_data),
        .bf_ready   (bf_ready),
        .bf_start   (bf_start),
        .bf_in_valid(bf_in_valid),
        .bf_in_ack  (bf_in_ack),
        .bf_in_data (bf_in_data),
        .prog_len   (prog_len),
        .overflow   (overflow),
        .busy       (busy),
        .err        (err)
    );

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic bit is_cmd(input logic [7:0] b);
        return b inside {8'h2B, 8'h2D, 8'h3C, 8'h3E,
                         8'h5B, 8'h5D, 8'h2E, 8'h2C};
    endfunction

    // Core model: drives bf_ready/bf_in_ack and checks every transfer.
    always begin
        @(negedge clk);
        bf_ready = core_ready;
        #1;
        if (!nrst) begin
            bf_in_ack  = 1'b0;
            prev_pend  = 1'b0;
            prev_start = 1'b0;
            age        = 0;
        end else begin
            if (bf_in_valid) begin
                age++;
                case (ack_mode)
                    1:       bf_in_ack = (age >= 5);
                    2:       bf_in_ack = 1'b0;
                    default: bf_in_ack = ($urandom_range(0, 2) != 0);
                endcase
            end else begin
                age       = 0;
                bf_in_ack = 1'b0;
            end
            #1;
            if (prev_pend && bf_ready == prev_ready) begin
                chk("hold_valid", int'(bf_in_valid), 1);
                chk("hold_data", int'(bf_in_data), int'(prev_data));
            end
            if (bf_in_valid) chk("src_ready_while_valid", int'(src_ready), 0);
            if (bf_in_valid && bf_in_ack) begin
                age = 0;
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got %02h, none expected",
                             bf_in_data);
                end else begin
                    e_item = exp_q.pop_front();
                    if (bf_in_data != e_item[7:0]) begin
                        errors++;
                        $display("FAIL write_data: got %02h expected %02h",
                                 bf_in_data, e_item[7:0]);
                    end
                    if (e_item[9:8] == 2'd0)
                        chk("code_while_ready", int'(bf_ready), 1);
                    else if (e_item[9:8] == 2'd2)
                        chk("runtime_while_busy", int'(bf_ready), 0);
                end
            end
            if (bf_start) begin
                chk("start_ready", int'(bf_ready), 1);
                chk("start_single", int'(prev_start), 0);
                start_cnt++;
                core_ready = 1'b0;
            end
            prev_start = bf_start;
            prev_pend  = bf_in_valid && !bf_in_ack;
            prev_data  = bf_in_data;
            prev_ready = bf_ready;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #4;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        src_valid = 1'b1;
        src_data  = b;
        while (!src_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("send_timeout", t, 0);
        @(negedge clk);
        src_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            wait_cyc(1);
            t++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic wait_start(input int old);
        int t = 0;
        while (start_cnt == old && t < 3000) begin
            wait_cyc(1);
            t++;
        end
        chk("start_seen", start_cnt, old + 1);
    endtask

    // Model: what the core must receive for the bytes in pgm.
    task automatic push_pgm(output int elen, output bit eovf);
        elen = 0;
        eovf = 1'b0;
        foreach (pgm[i]) begin
            if (pgm[i] == 8'h21) break;
            if (is_cmd(pgm[i])) begin
                if (elen < MAX_LEN) begin
                    exp_q.push_back({2'd0, pgm[i]});
                    elen++;
                end else begin
                    eovf = 1'b1;
                end
            end
        end
        exp_q.push_back({2'd1, 8'h00});
        foreach (pgm[i]) send(pgm[i]);
    endtask

    task automatic run_pgm(output int elen, output bit eovf);
        int old;
        old = start_cnt;
        push_pgm(elen, eovf);
        wait_start(old);
        wait_cyc(1);
        chk("prog_len", int'(prog_len), elen);
        chk("overflow", int'(overflow), int'(eovf));
        chk("busy_run", int'(busy), 1);
    endtask

    task automatic rearm();
        wait_drain();
        wait_cyc(2);
        core_ready = 1'b1;
        wait_cyc(3);
        chk("rearm_busy", int'(busy), 0);
        chk("rearm_prog_len", int'(prog_len), 0);
        chk("rearm_overflow", int'(overflow), 0);
    endtask

    task automatic check_rst();
        chk("rst_src_ready", int'(src_ready), 1);
        chk("rst_start", int'(bf_start), 0);
        chk("rst_in_valid", int'(bf_in_valid), 0);
        chk("rst_in_data", int'(bf_in_data), 0);
        chk("rst_prog_len", int'(prog_len), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
    endtask

    task automatic set_str(input string s);
        pgm.delete();
        for (int i = 0; i < s.len(); i++) pgm.push_back(s[i]);
    endtask

    logic [7:0] tbl [12] = '{8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C,
                             8'h00, 8'h61, 8'h0A, 8'hFF, 8'h5B, 8'h5D};

    initial begin
        int  elen;
        bit  eovf;
        int  hi;
        int  old;
        logic [7:0] b;

        #3;
        check_rst();
        wait_cyc(2);
        nrst = 1'b1;
        wait_cyc(1);

        // Basic program with noise bytes.
        set_str("+ +.\n!");
        run_pgm(elen, eovf);
        chk("lit_prog_len", int'(prog_len), 3);
        chk("lit_overflow", int'(overflow), 0);
        chk("lit_start_cnt", start_cnt, 1);

        // Slow core ack on a runtime byte.
        ack_mode = 1;
        exp_q.push_back({2'd2, 8'h41});
        send(8'h41);
        wait_drain();
        ack_mode = 0;
        rearm();

        // Overflow past MAX_LEN.
        pgm.delete();
        repeat (300) pgm.push_back(8'h2B);
        pgm.push_back(8'h21);
        run_pgm(elen, eovf);
        chk("lit_ovf_len", int'(prog_len), 255);
        chk("lit_ovf_flag", int'(overflow), 1);
        rearm();

        // Core returns to ready with a runtime byte still buffered.
        set_str(".!");
        run_pgm(elen, eovf);
        ack_mode = 2;
        send(8'h7A);
        wait_cyc(2);
        chk("buffered_valid", int'(bf_in_valid), 1);
        core_ready = 1'b1;
        wait_cyc(1);
        chk("no_valid_on_ready", int'(bf_in_valid), 0);
        wait_cyc(2);
        chk("drop_busy", int'(busy), 0);
        chk("drop_prog_len", int'(prog_len), 0);
        chk("drop_valid", int'(bf_in_valid), 0);
        ack_mode = 0;
        wait_cyc(3);
        chk("drop_valid_later", int'(bf_in_valid), 0);

        // Reset in the middle of a load.
        exp_q.push_back({2'd0, 8'h2B});
        exp_q.push_back({2'd0, 8'h2D});
        send(8'h2B);
        send(8'h2D);
        wait_drain();
        wait_cyc(1);
        chk("mid_prog_len", int'(prog_len), 2);
        @(negedge clk);
        #3;
        nrst = 1'b0;
        #1;
        check_rst();
        exp_q.delete();
        wait_cyc(2);
        nrst = 1'b1;
        wait_cyc(1);
        set_str("><.!");
        run_pgm(elen, eovf);
        chk("post_rst_len", int'(prog_len), 3);
        rearm();

        // Random programs and runtime input.
`ifdef BF_LOADER_CHECK_EN
        hi = 9;
`else
        hi = 11;
`endif
        for (int it = 0; it < 6; it++) begin
            pgm.delete();
            repeat ($urandom_range(1, 40))
                pgm.push_back(tbl[$urandom_range(0, hi)]);
            pgm.push_back(8'h21);
            run_pgm(elen, eovf);
            repeat ($urandom_range(1, 6)) begin
                b = 8'($urandom_range(0, 255));
                exp_q.push_back({2'd2, b});
                send(b);
            end
            rearm();
        end

`ifdef BF_LOADER_CHECK_EN
        // Unbalanced brackets end in ERR.
        old = start_cnt;
        set_str("[[]!");
        push_pgm(elen, eovf);
        wait_drain();
        wait_cyc(3);
        chk("err_flag", int'(err), 1);
        chk("err_busy", int'(busy), 1);
        for (int i = 0; i < 20; i++) begin
            chk("err_src_ready", int'(src_ready), 0);
            wait_cyc(1);
        end
        chk("err_no_start", start_cnt, old);
        @(negedge clk);
        #3;
        nrst = 1'b0;
        #1;
        check_rst();
        wait_cyc(2);
        nrst = 1'b1;
        wait_cyc(1);
`else
        old = start_cnt;
        chk("err_tied", int'(err), 0);
        chk("start_total", old, start_cnt);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
